// File: rtl/i2s_pkg.sv
// i2s_pkg: shared I2S defaults, channel encoding and receiver state type.
package i2s_pkg;

   localparam int I2S_DEFAULT_SAMPLE_WIDTH   = 16;
   localparam int I2S_DEFAULT_BITS_PER_FRAME = 64;

   // WS level on the wire: 0 selects the left channel, 1 the right.
   typedef enum logic {
      I2S_LEFT  = 1'b0,
      I2S_RIGHT = 1'b1
   } i2s_chan_t;

   typedef enum logic {
      WAIT_WS = 1'b0,
      RUN     = 1'b1
   } i2s_rx_state_t;

endpackage

// File: rtl/i2s_sync.sv
// i2s_sync: WIDTH-bit two-flop synchroniser with synchronous active-high reset.
module i2s_sync #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] s1;

   // Two-stage capture of asynchronous inputs into the clk domain.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1 <= '0;
         q  <= '0;
      end else begin
         s1 <= d;
         q  <= s1;
      end
   end

endmodule

// File: rtl/i2s_rx.sv
// i2s_rx: I2S stereo receiver in the clk domain. SCLK/WS/SD are synchronised,
// SCLK rises are edge-detected, and one sample_valid pulse is emitted per
// complete left+right pair.
// Optional half-frame length checking is compiled in with I2S_RX_FRAME_CHECK_EN;
// without it frame_error is tied low.
module i2s_rx
   import i2s_pkg::*;
#(
   parameter int SAMPLE_WIDTH   = I2S_DEFAULT_SAMPLE_WIDTH,
   parameter int BITS_PER_FRAME = I2S_DEFAULT_BITS_PER_FRAME
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    i2s_sclk,
   input  logic                    i2s_ws,
   input  logic                    i2s_sd,
   output logic [SAMPLE_WIDTH-1:0] left_channel,
   output logic [SAMPLE_WIDTH-1:0] right_channel,
   output logic                    sample_valid,
   output logic                    frame_error
);

   localparam int             CW   = $clog2(SAMPLE_WIDTH + 1);
   localparam logic [CW-1:0]  FULL = CW'(SAMPLE_WIDTH);

   logic [2:0]              sync_q;
   logic                    sclk_s2, ws_s2, sd_s2, sclk_s3;
   logic                    sclk_rise, ws_chg, shift_en;
   logic                    ws_prev;
   logic [CW-1:0]           bit_cnt;
   i2s_chan_t               chan;
   logic [SAMPLE_WIDTH-1:0] word;
   logic                    word_done;
   logic [SAMPLE_WIDTH-1:0] left_hold;
   logic                    left_ok;
   i2s_rx_state_t           state, state_nxt;

   i2s_sync #(.WIDTH(3)) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     ({i2s_sd, i2s_ws, i2s_sclk}),
      .q     (sync_q)
   );

   assign {sd_s2, ws_s2, sclk_s2} = sync_q;

   // Third SCLK stage, used only for rise detection.
   always_ff @(posedge clk) begin
      if (reset) sclk_s3 <= 1'b0;
      else       sclk_s3 <= sclk_s2;
   end

   assign sclk_rise = sclk_s2 & ~sclk_s3;
   assign ws_chg    = sclk_rise & (ws_s2 != ws_prev);
   // Bits on the WS-change rise are the LSB slot of the previous word; bits
   // beyond SAMPLE_WIDTH (long codec slots) are truncated.
   assign shift_en  = sclk_rise & ~ws_chg & (state == RUN) & (bit_cnt != FULL);

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= WAIT_WS;
      else       state <= state_nxt;
   end

   // Next state: shifting is held off until the first WS edge gives alignment.
   always_comb begin
      state_nxt = state;
      case (state)
         WAIT_WS: if (ws_chg) state_nxt = RUN;
         RUN:     state_nxt = RUN;
         default: state_nxt = WAIT_WS;
      endcase
   end

   // Bit counter, channel tracking and word shift register.
   always_ff @(posedge clk) begin
      if (reset) begin
         ws_prev   <= 1'b0;
         bit_cnt   <= '0;
         chan      <= I2S_LEFT;
         word      <= '0;
         word_done <= 1'b0;
      end else begin
         word_done <= shift_en && (bit_cnt == FULL - 1'b1);
         if (sclk_rise) ws_prev <= ws_s2;
         if (ws_chg) begin
            // A partial word is simply abandoned; the counter restart discards it.
            bit_cnt <= '0;
            chan    <= i2s_chan_t'(ws_s2);
         end else if (shift_en) begin
            word    <= {word[SAMPLE_WIDTH-2:0], sd_s2};
            bit_cnt <= bit_cnt + 1'b1;
         end
      end
   end

   // Word completion: park left words, publish only on a right word with a left pending.
   always_ff @(posedge clk) begin
      if (reset) begin
         left_hold     <= '0;
         left_ok       <= 1'b0;
         left_channel  <= '0;
         right_channel <= '0;
         sample_valid  <= 1'b0;
      end else begin
         sample_valid <= 1'b0;
         if (word_done) begin
            if (chan == I2S_LEFT) begin
               left_hold <= word;
               left_ok   <= 1'b1;
            end else if (left_ok) begin
               left_channel  <= left_hold;
               right_channel <= word;
               sample_valid  <= 1'b1;
               left_ok       <= 1'b0;
            end
         end
      end
   end

`ifdef I2S_RX_FRAME_CHECK_EN
   localparam logic [6:0] HALF_BITS = 7'(BITS_PER_FRAME / 2);

   logic [6:0] half_cnt;
   logic       seen_chg;

   // Half-frame length check; the first WS edge after reset has no reference.
   always_ff @(posedge clk) begin
      if (reset) begin
         half_cnt    <= '0;
         seen_chg    <= 1'b0;
         frame_error <= 1'b0;
      end else if (sclk_rise) begin
         if (ws_chg) begin
            if (seen_chg && ((half_cnt != HALF_BITS) || (bit_cnt != FULL)))
               frame_error <= 1'b1;
            seen_chg <= 1'b1;
            half_cnt <= 7'd1;
         end else if (half_cnt != 7'h7f) begin
            half_cnt <= half_cnt + 7'd1;
         end
      end
   end
`else
   assign frame_error = 1'b0;
`endif

endmodule

// File: tb/tb_i2s_rx.sv
// tb_i2s_rx: directed-vector bench for i2s_rx at clk/4 SCLK.
module tb_i2s_rx;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        i2s_sclk = 1'b0;
   logic        i2s_ws = 1'b0;
   logic        i2s_sd = 1'b0;
   logic [15:0] left_channel, right_channel;
   logic        sample_valid, frame_error;

   int npass = 0;
   int ntot  = 0;
   int cyc   = 0;
   int vld_cnt = 0;
   int vld_cyc = -1;
   int e0 = -100;
   int base;
   logic [15:0] cap_l = '0, cap_r = '0;
   logic fe_exp;

   i2s_rx dut (
      .clk           (clk),
      .reset         (reset),
      .i2s_sclk      (i2s_sclk),
      .i2s_ws        (i2s_ws),
      .i2s_sd        (i2s_sd),
      .left_channel  (left_channel),
      .right_channel (right_channel),
      .sample_valid  (sample_valid),
      .frame_error   (frame_error)
   );

   always #5 clk = ~clk;

   // Count clk edges and record every sample_valid pulse, sampled 1ns after the edge.
   always @(posedge clk) begin
      cyc = cyc + 1;
      #1;
      if (sample_valid) begin
         vld_cnt = vld_cnt + 1;
         vld_cyc = cyc;
         cap_l   = left_channel;
         cap_r   = right_channel;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      ntot = ntot + 1;
      if (got === exp) npass = npass + 1;
      else $display("FAIL %s: got %0h, required %0h", tag, got, exp);
   endtask

   // One SCLK period: 2 clk low (data/WS set on the fall), 2 clk high.
   // Called and returns at 1ns after a clk edge.
   task automatic send_bit(input logic ws, input logic sd, input bit mark);
      i2s_sclk = 1'b0;
      i2s_ws   = ws;
      i2s_sd   = sd;
      repeat (2) @(posedge clk);
      #1 i2s_sclk = 1'b1;
      if (mark) e0 = cyc + 1;
      repeat (2) @(posedge clk);
      #1;
   endtask

   // Half-frame of nbits SCLKs. Bit 0 is the ignored LSB slot; bit i>=1 is slot[32-i].
   task automatic send_half(input logic ws, input logic [31:0] slot, input int nbits);
      for (int i = 0; i < nbits; i++)
         send_bit(ws, (i == 0) ? 1'b0 : slot[32-i], (ws == 1'b1) && (i == 16));
   endtask

   task automatic send_frame(input logic [31:0] ls, input logic [31:0] rs);
      send_half(1'b0, ls, 32);
      send_half(1'b1, rs, 32);
   endtask

   task automatic do_reset();
      i2s_sclk = 1'b0;
      i2s_ws   = 1'b0;
      i2s_sd   = 1'b0;
      reset    = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   initial begin
      @(posedge clk);
      #1;
      do_reset();
      chk("rst_left",  {16'h0, left_channel},  32'h0);
      chk("rst_right", {16'h0, right_channel}, 32'h0);
      chk("rst_valid", {31'h0, sample_valid},  32'h0);
      chk("rst_ferr",  {31'h0, frame_error},   32'h0);

      // Basic 16-bit words in 32-bit slots; first frame only aligns.
      base = vld_cnt;
      send_frame({16'hA5C3, 16'h0}, {16'h3C5A, 16'h0});
      chk("t1_align_no_pulse", vld_cnt - base, 0);
      send_frame({16'hA5C3, 16'h0}, {16'h3C5A, 16'h0});
      chk("t1_one_pulse", vld_cnt - base, 1);
      chk("t1_left",  {16'h0, cap_l}, 32'hA5C3);
      chk("t1_right", {16'h0, cap_r}, 32'h3C5A);
      chk("t1_latency", vld_cyc - e0, 3);
      send_frame({16'hA5C3, 16'h0}, {16'h3C5A, 16'h0});
      chk("t1_two_pulses", vld_cnt - base, 2);
      chk("t1_latency2", vld_cyc - e0, 3);
      chk("t1_hold_left", {16'h0, left_channel}, 32'hA5C3);
      chk("t1_ferr", {31'h0, frame_error}, 32'h0);

      // 24-bit data in 32-bit slots truncates to the top 16 bits.
      do_reset();
      base = vld_cnt;
      send_frame({24'h123456, 8'h0}, {24'hFEDCBA, 8'h0});
      send_frame({24'h123456, 8'h0}, {24'hFEDCBA, 8'h0});
      chk("t2_one_pulse", vld_cnt - base, 1);
      chk("t2_left",  {16'h0, cap_l}, 32'h1234);
      chk("t2_right", {16'h0, cap_r}, 32'hFEDC);

      // Stream starting mid-right: the tail of that right word must not publish.
      do_reset();
      base = vld_cnt;
      for (int i = 0; i < 20; i++) send_bit(1'b1, 1'b1, 1'b0);
      chk("t3_no_pulse_midright", vld_cnt - base, 0);
      send_frame({16'h1111, 16'h0}, {16'h2222, 16'h0});
      chk("t3_one_pulse", vld_cnt - base, 1);
      chk("t3_left",  {16'h0, cap_l}, 32'h1111);
      chk("t3_right", {16'h0, cap_r}, 32'h2222);

      // Reset at bit 8 of a left word under all-ones traffic.
      do_reset();
      send_frame(32'hFFFF_0000, 32'hFFFF_0000);
      send_frame(32'hFFFF_0000, 32'hFFFF_0000);
      chk("t4_pre_left", {16'h0, left_channel}, 32'hFFFF);
      for (int i = 0; i < 8; i++) send_bit(1'b0, (i == 0) ? 1'b0 : 1'b1, 1'b0);
      i2s_sclk = 1'b0;
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("t4_rst_left",  {16'h0, left_channel},  32'h0);
      chk("t4_rst_right", {16'h0, right_channel}, 32'h0);
      chk("t4_rst_valid", {31'h0, sample_valid},  32'h0);
      reset = 1'b0;
      base = vld_cnt;
      for (int i = 8; i < 32; i++) send_bit(1'b0, (i <= 16) ? 1'b1 : 1'b0, 1'b0);
      send_half(1'b1, 32'hFFFF_0000, 32);
      chk("t4_no_pulse_after_rst", vld_cnt - base, 0);
      send_frame({16'h1234, 16'h0}, {16'h5678, 16'h0});
      chk("t4_one_pulse", vld_cnt - base, 1);
      chk("t4_left",  {16'h0, cap_l}, 32'h1234);
      chk("t4_right", {16'h0, cap_r}, 32'h5678);

      // Short left half-frame of 10 SCLKs drops the pair.
`ifdef I2S_RX_FRAME_CHECK_EN
      fe_exp = 1'b1;
`else
      fe_exp = 1'b0;
`endif
      do_reset();
      base = vld_cnt;
      send_frame({16'h0F0F, 16'h0}, {16'hF0F0, 16'h0});
      send_frame({16'h0F0F, 16'h0}, {16'hF0F0, 16'h0});
      chk("t5_pre_pulse", vld_cnt - base, 1);
      chk("t5_pre_ferr", {31'h0, frame_error}, 32'h0);
      send_half(1'b0, {16'hAAAA, 16'h0}, 10);
      send_half(1'b1, {16'h5555, 16'h0}, 32);
      chk("t5_short_dropped", vld_cnt - base, 1);
      chk("t5_short_hold_right", {16'h0, right_channel}, 32'hF0F0);
      chk("t5_ferr_set", {31'h0, frame_error}, {31'h0, fe_exp});
      send_frame({16'h7E81, 16'h0}, {16'h8118, 16'h0});
      chk("t5_recover_pulse", vld_cnt - base, 2);
      chk("t5_recover_left",  {16'h0, cap_l}, 32'h7E81);
      chk("t5_recover_right", {16'h0, cap_r}, 32'h8118);
      chk("t5_ferr_sticky", {31'h0, frame_error}, {31'h0, fe_exp});

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule

// File: doc/i2s_rx.md
# i2s_rx

I2S receiver that deserialises a stereo I2S stream from an external codec ADC or a loopback of our I2S transmitter into parallel left/right samples. It runs in the system `clk` domain and treats `i2s_sclk`, `i2s_ws` and `i2s_sd` as asynchronous inputs. Each input is synchronised and `i2s_sclk` rising edges are detected with `clk`. It sits between the board audio pins and the audio capture/mixing logic and emits one `sample_valid` pulse per complete stereo frame.

## Interface
- `SAMPLE_WIDTH`, 16, bits captured per channel word, MSB first.
- `BITS_PER_FRAME`, 64, nominal SCLK periods per stereo frame; used only by the frame check.
- `clk`  input  1  system clock; all logic on its rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `i2s_sclk`  input  1  bit clock, asynchronous to `clk`.
- `i2s_ws`  input  1  word select: 0 = left, 1 = right; asynchronous.
- `i2s_sd`  input  1  serial data, changes on SCLK falling edge; asynchronous.
- `left_channel`  output  SAMPLE_WIDTH  last complete left word.
- `right_channel`  output  SAMPLE_WIDTH  last complete right word.
- `sample_valid`  output  1  one-`clk` pulse when both channel outputs update.
- `frame_error`  output  1  sticky half-frame length error; constant 0 unless the frame-check feature is compiled in.

## Operation
- **Synchroniser:** two flops on each of `i2s_sclk`, `i2s_ws` and `i2s_sd`. A third flop on synchronised SCLK supports edge detection. A rise is `sclk_s2 && !sclk_s3`. WS and SD are taken from stage 2 in that same cycle.
- **Per SCLK rise:**
  - Compare WS against `ws_prev`, the WS value at the previous rise.
  - **WS changed:** the current bit is the LSB slot of the outgoing word and is ignored.
    - Clear `bit_cnt`.
    - Set `chan` to the new WS value.
    - Discard any partial word; under the frame-check feature this sets `frame_error`.
  - **WS unchanged and `bit_cnt < SAMPLE_WIDTH`:** shift SD into the word register LSB-side and increment `bit_cnt`.
  - **`bit_cnt == SAMPLE_WIDTH`:** ignore further bits (long words, e.g. 24/32-bit codec slots, are truncated to their MSBs) and do not increment `bit_cnt`.
- **Word completion:** occurs when `bit_cnt` reaches SAMPLE_WIDTH.
  - `chan == 0`: move the word to the left hold register and set `left_ok`.
  - `chan == 1` and `left_ok`: publish the left hold register and the right word to the outputs, pulse `sample_valid`, and clear `left_ok`.
  - `chan == 1` and not `left_ok`: drop the word.
- **States:**
  - `WAIT_WS`: after reset; shifting is disabled until the first WS change.
  - `RUN`: normal operation.
  - The first complete left word in `RUN` followed by a complete right word yields the first `sample_valid`. A stream that starts mid-right produces no output until a full left+right pair arrives.
- **Reset:** all synchroniser flops, `ws_prev`, `bit_cnt`, `left_ok`, the word/hold registers and all outputs are cleared, and the state returns to `WAIT_WS`. This applies on any cycle, including mid-word.

## Timing
- Reset values: `left_channel = 0`, `right_channel = 0`, `sample_valid = 0`, `frame_error = 0`.
- SCLK high and low phases must each be ≥ 2 `clk` periods (clk/sclk ratio ≥ 4; 12.288 MHz / 3.072 MHz meets this exactly).
- Latency: let edge E0 be the `clk` edge that first samples SCLK high on the rise carrying the right-word bit SAMPLE_WIDTH-1.
  - The shift happens at edge E0+2.
  - Outputs and `sample_valid` are registered at E0+3.
  - `sample_valid` is high for exactly the cycle after E0+3.
- Outputs hold their value between pulses; they never change without `sample_valid`.
- WS change and word completion cannot occur on the same rise. If a WS change coincides with `bit_cnt == SAMPLE_WIDTH-1`, the word is incomplete and is discarded.

## Configuration
- `I2S_RX_FRAME_CHECK_EN`
  - **Defined:** a 7-bit `half_cnt` counts SCLK rises per WS half-frame. On each WS change, `frame_error` sets if `half_cnt != BITS_PER_FRAME/2` or if a word was discarded. The first WS change after reset is exempt. `frame_error` clears only on reset.
  - **Undefined:** the counter is absent and `frame_error` is tied 0.

## Structure
- Package `i2s_pkg`: `I2S_DEFAULT_SAMPLE_WIDTH`, `I2S_DEFAULT_BITS_PER_FRAME`, channel enum (`I2S_LEFT = 0`, `I2S_RIGHT = 1`), `i2s_rx_state_t` (`WAIT_WS`, `RUN`). Shared with the transmitter.
- Sub-module `i2s_sync`: parameterised-width 2-flop synchroniser with synchronous reset, instantiated once for the 3-bit input bus.

## Test plan
- 64-bit frames at clk/4, left = 16'hA5C3, right = 16'h3C5A -> `sample_valid` once per frame with exactly those values, at E0+3.
- 32-bit slots carrying 24-bit data 24'h123456 / 24'hFEDCBA -> outputs 16'h1234 / 16'hFEDC.
- Stream starting mid-right word -> no `sample_valid` until a full left+right pair arrives; the first outputs match that pair.
- Reset asserted at bit 8 of a left word with 16'hFFFF traffic -> all outputs 0 next cycle. No pulse until the next full frame after a new WS change.
- With `I2S_RX_FRAME_CHECK_EN`, one half-frame shortened to 10 SCLKs -> the word is dropped, `frame_error` = 1 and stays 1; valid frames continue to decode.
- Without the macro, the same short half-frame -> `frame_error` stays 0 and the word is dropped.
